// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage data-memory handshake FSM (IDLE/REQ/DONE); REQ timeout built only with `MEM_TIMEOUT_EN.
// Latency: one access cycle plus one cycle per REQ cycle until ack. Backpressure: stall_o holds the pipeline while memory withholds dmem_ack_i.
module mem_stage_ctrl #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        timeout_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  logic   access;

  assign access = memread_i | memwrite_i;

  // The access cycle itself must stall so EX/MEM holds the operands until DONE.
  assign stall_o = ((state_q == IDLE) && access) || (state_q == REQ);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic       timeout_err_q;

  assign timeout_err_o = timeout_err_q;
`else
  logic unused_cfg;

  assign timeout_err_o = 1'b0;
  assign unused_cfg    = ^{ERR_RDATA, 8'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_addr_o   <= 32'h0;
      dmem_wdata_o  <= 32'h0;
      rdata_o       <= 32'h0;
`ifdef MEM_TIMEOUT_EN
      cnt_q         <= 8'h0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_q      <= REQ;
            dmem_req_o   <= 1'b1;
            // read+write together resolves to a write
            dmem_we_o    <= memwrite_i;
            dmem_addr_o  <= addr_i;
            dmem_wdata_o <= wdata_i;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= 8'h0;
`endif
          end
        end
        REQ: begin
`ifdef MEM_TIMEOUT_EN
          cnt_q <= cnt_q + 8'd1;
`endif
          if (dmem_ack_i) begin
            if (!dmem_we_o) rdata_o <= dmem_rdata_i;
            dmem_req_o <= 1'b0;
            state_q    <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          // A same-cycle ack takes the branch above, so expiry never overrides it.
          else if (cnt_q == CNT_LAST) begin
            if (!dmem_we_o) rdata_o <= ERR_RDATA;
            timeout_err_q <= 1'b1;
            dmem_req_o    <= 1'b0;
            state_q       <= DONE;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          dmem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; timeout cases adapt to whether MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        memread_i;
  logic        memwrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        timeout_err_o;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_ctrl #(
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .memread_i    (memread_i),
    .memwrite_i   (memwrite_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .rdata_o      (rdata_o),
    .stall_o      (stall_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one access from IDLE; acks on REQ cycle ack_on (0 = never).
  // Returns in the first non-stalled cycle, or with stall_o still high if budget runs out.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rv,
                           input int ack_on, input int budget,
                           output int stalls, output int reqs);
    memread_i  = rd;
    memwrite_i = wr;
    addr_i     = a;
    wdata_i    = d;
    #1;
    stalls = 0;
    reqs   = 0;
    for (int c = 0; c < budget; c++) begin
      if (!stall_o) break;
      stalls++;
      if (dmem_req_o) begin
        reqs++;
        chk("req_we", {31'h0, dmem_we_o}, {31'h0, wr});
        chk("req_addr", dmem_addr_o, a);
        chk("req_wdata", dmem_wdata_o, d);
        memread_i    = 1'b0;
        memwrite_i   = 1'b0;
        addr_i       = 32'hFFFF_0000;
        wdata_i      = 32'h0000_FFFF;
        dmem_ack_i   = (reqs == ack_on);
        dmem_rdata_i = rv;
      end
      tick();
      dmem_ack_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         st;
    int         rq;
    logic [8:0] stall_v;
    logic [8:0] req_v;

    rst_n_i      = 1'b0;
    memread_i    = 1'b0;
    memwrite_i   = 1'b0;
    addr_i       = 32'h0;
    wdata_i      = 32'h0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;

    // reset values, stall driven only by the request inputs
    #12;
    chk("rst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("rst_we", {31'h0, dmem_we_o}, 32'h0);
    chk("rst_addr", dmem_addr_o, 32'h0);
    chk("rst_wdata", dmem_wdata_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", {31'h0, timeout_err_o}, 32'h0);
    chk("rst_stall0", {31'h0, stall_o}, 32'h0);
    memread_i = 1'b1;
    #1;
    chk("rst_stall1", {31'h0, stall_o}, 32'h1);
    memread_i = 1'b0;
    #1;
    tick();
    rst_n_i = 1'b1;
    tick();
    chk("idle_req", {31'h0, dmem_req_o}, 32'h0);

    // read at 0x40, immediate ack
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 1, 20, st, rq);
    chk("rd_stalls", 32'(st), 32'd2);
    chk("rd_reqs", 32'(rq), 32'd1);
    chk("rd_rdata", rdata_o, 32'h1234_5678);
    chk("rd_done_req", {31'h0, dmem_req_o}, 32'h0);
    // ack while in DONE must be ignored
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    tick();
    dmem_ack_i = 1'b0;
    chk("done_ack_rdata", rdata_o, 32'h1234_5678);
    chk("done_ack_stall", {31'h0, stall_o}, 32'h0);

    // write at 0x80, ack on 3rd REQ cycle
    do_access(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 32'h5555_AAAA, 3, 20, st, rq);
    chk("wr_stalls", 32'(st), 32'd4);
    chk("wr_reqs", 32'(rq), 32'd3);
    chk("wr_rdata_kept", rdata_o, 32'h1234_5678);
    tick();

    // ack in IDLE with no access must be ignored
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0F0F_0F0F;
    tick();
    dmem_ack_i = 1'b0;
    chk("idle_ack_req", {31'h0, dmem_req_o}, 32'h0);
    chk("idle_ack_rdata", rdata_o, 32'h1234_5678);

    // read+write held high across DONE: one burst per access, new access only from IDLE
    memread_i  = 1'b1;
    memwrite_i = 1'b1;
    addr_i     = 32'h0000_00C0;
    wdata_i    = 32'h0000_0011;
    for (int c = 0; c < 9; c++) begin
      #1;
      stall_v[c] = stall_o;
      req_v[c]   = dmem_req_o;
      if (dmem_req_o) chk("hold_we", {31'h0, dmem_we_o}, 32'h1);
      dmem_ack_i = dmem_req_o;
      if (c == 8) begin
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
      end
      tick();
      dmem_ack_i = 1'b0;
    end
    chk("hold_stall_pat", {23'h0, stall_v}, {23'h0, 9'b011011011});
    chk("hold_req_pat", {23'h0, req_v}, {23'h0, 9'b010010010});
    chk("hold_rdata_kept", rdata_o, 32'h1234_5678);

    // ack on the 4th REQ cycle: normal completion even with timeout at 4
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hA5A5_0F0F, 4, 20, st, rq);
    chk("ack4_stalls", 32'(st), 32'd5);
    chk("ack4_reqs", 32'(rq), 32'd4);
    chk("ack4_rdata", rdata_o, 32'hA5A5_0F0F);
    chk("ack4_err", {31'h0, timeout_err_o}, 32'h0);
    tick();

    // no ack at all
`ifdef MEM_TIMEOUT_EN
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 32'h0, 0, 20, st, rq);
    chk("to_stalls", 32'(st), 32'd5);
    chk("to_reqs", 32'(rq), 32'd4);
    chk("to_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("to_err", {31'h0, timeout_err_o}, 32'h1);
    tick();
    chk("to_err_sticky", {31'h0, timeout_err_o}, 32'h1);
    chk("to_idle_stall", {31'h0, stall_o}, 32'h0);
`else
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 32'h0, 0, 12, st, rq);
    chk("wait_reqs", 32'(rq), 32'd11);
    chk("wait_stall", {31'h0, stall_o}, 32'h1);
    chk("wait_req", {31'h0, dmem_req_o}, 32'h1);
    chk("wait_err", {31'h0, timeout_err_o}, 32'h0);
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h0BAD_CAFE;
    tick();
    dmem_ack_i = 1'b0;
    chk("wait_rdata", rdata_o, 32'h0BAD_CAFE);
    chk("wait_done_stall", {31'h0, stall_o}, 32'h0);
    tick();
`endif

    // reset pulse on the 2nd REQ cycle
    memread_i = 1'b1;
    addr_i    = 32'h0000_0100;
    #1;
    tick();
    memread_i = 1'b0;
    chk("rq2_req1", {31'h0, dmem_req_o}, 32'h1);
    tick();
    chk("rq2_req2", {31'h0, dmem_req_o}, 32'h1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_req", {31'h0, dmem_req_o}, 32'h0);
    chk("arst_addr", dmem_addr_o, 32'h0);
    chk("arst_rdata", rdata_o, 32'h0);
    chk("arst_err", {31'h0, timeout_err_o}, 32'h0);
    chk("arst_stall", {31'h0, stall_o}, 32'h0);
    rst_n_i      = 1'b1;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h7777_7777;
    tick();
    dmem_ack_i = 1'b0;
    chk("late_ack_req", {31'h0, dmem_req_o}, 32'h0);
    chk("late_ack_rdata", rdata_o, 32'h0);
    chk("late_ack_stall", {31'h0, stall_o}, 32'h0);

    // normal operation resumes after reset
    do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h2468_ACE0, 1, 20, st, rq);
    chk("post_stalls", 32'(st), 32'd2);
    chk("post_rdata", rdata_o, 32'h2468_ACE0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
